// File: rtl/serial_paralelo_if.sv
// Serial-to-parallel bus: serial bit in, aligned byte out.
// The slave side is the converter; the master side feeds it and consumes its outputs.
interface serial_paralelo_if;
  logic       data_serial;
  logic [7:0] data_serial_paralelo;
  logic       valid_serial_paralelo;
  logic       active_serial_paralelo;
  logic       strobe_serial_paralelo;

  modport master (
    output data_serial,
    input  data_serial_paralelo,
    input  valid_serial_paralelo,
    input  active_serial_paralelo,
    input  strobe_serial_paralelo
  );

  modport slave (
    input  data_serial,
    output data_serial_paralelo,
    output valid_serial_paralelo,
    output active_serial_paralelo,
    output strobe_serial_paralelo
  );
endinterface

// File: rtl/serial_paralelo.sv
// PHY receive serial-to-parallel converter.
// Locks byte alignment on a run of COM symbols, then emits one byte per 8 clocks.
module serial_paralelo #(
  parameter logic [7:0]  COM       = 8'hBC,
  parameter int unsigned COM_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  serial_paralelo_if.slave  bus
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  localparam logic [3:0] COM_TGT = 4'(COM_COUNT);

  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [1:0] state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
  logic       strobe_q, strobe_d;

  logic [7:0] w;
  logic       is_com;
  logic       boundary;

  // Next-state: bit-wise COM search, byte-wise COM counting, byte output.
  always_comb begin
    w         = {sr_q[6:0], bus.data_serial};
    is_com    = (w == COM);
    boundary  = (bit_cnt_q == 3'd7);
    sr_d      = w;
    bit_cnt_d = bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    unique case (state_q)
      HUNT: begin
        bit_cnt_d = 3'd0;
        com_cnt_d = 4'd0;
        if (is_com) begin
          com_cnt_d = 4'd1;
          state_d   = (COM_TGT == 4'd1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (com_cnt_d == COM_TGT) state_d = ACTIVE;
          end else begin
            com_cnt_d = 4'd0;
            bit_cnt_d = 3'd0;
            state_d   = HUNT;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          data_d   = w;
          valid_d  = !is_com;
          strobe_d = 1'b1;
        end
      end
      default: begin
        bit_cnt_d = 3'd0;
        com_cnt_d = 4'd0;
        state_d   = HUNT;
      end
    endcase
    active_d = (state_d == ACTIVE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr_q      <= 8'd0;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      state_q   <= HUNT;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      strobe_q  <= strobe_d;
    end
  end

  assign bus.data_serial_paralelo   = data_q;
  assign bus.valid_serial_paralelo  = valid_q;
  assign bus.active_serial_paralelo = active_q;
  assign bus.strobe_serial_paralelo = strobe_q;

endmodule
